seg_scan_ctrl: RTL

- Consumer of the 480 Hz LED scan clock. Drives eight multiplexed, common-anode seven-segment digits from a 32-bit hex value, one digit per scan-clock rising edge.
- Runs entirely on the 100 MHz system clock. The scan clock is treated as a data input: synchronised, then edge-detected.
- Double-buffers display data so updates never tear mid-frame, and inserts a blanking gap at each digit change to suppress ghosting.

---
 rtl/seg_pkg.sv | 15 +
 rtl/hex_to_7seg.sv | 28 ++
 rtl/seg_scan_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and FSM state type for the multiplexed seven-segment scan controller.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder, output bits {g,f,e,d,c,b,a}.
module hex_to_7seg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_nibble)
            4'h0:    o_seg = 7'h40;
            4'h1:    o_seg = 7'h79;
            4'h2:    o_seg = 7'h24;
            4'h3:    o_seg = 7'h30;
            4'h4:    o_seg = 7'h19;
            4'h5:    o_seg = 7'h12;
            4'h6:    o_seg = 7'h02;
            4'h7:    o_seg = 7'h78;
            4'h8:    o_seg = 7'h00;
            4'h9:    o_seg = 7'h10;
            4'hA:    o_seg = 7'h08;
            4'hB:    o_seg = 7'h03;
            4'hC:    o_seg = 7'h46;
            4'hD:    o_seg = 7'h21;
            4'hE:    o_seg = 7'h06;
            default: o_seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit common-anode scan controller with double-buffered data and per-digit blanking gap.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int BLANK_CYC   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        scan_clk,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        frame_done,
    output logic        update_pending
);

    localparam logic [7:0]       BLANK_LOAD = 8'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    state_t                 r_state;
    logic [7:0]             r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [31:0]            r_shadow;
    logic [7:0]             r_shadow_dp;
    logic [31:0]            r_active;
    logic [7:0]             r_active_dp;
    logic                   r_pending;
    logic [7:0]             r_anode;
    logic [6:0]             r_cathode;
    logic                   r_dp;
    logic                   r_frame_done;

    logic                   w_scan_edge;
    state_t                 w_state_nxt;
    logic [7:0]             w_cnt_nxt;
    logic                   w_adv;
    logic                   w_wrap;
    logic [3:0]             w_nibble;
    logic [6:0]             w_dec;
    logic [6:0]             w_seg;

    // The scan clock is asynchronous: resample it before edge detection.
    // NOTE: every clocked register uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], scan_clk};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_scan_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_scan_edge) begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = BLANK_LOAD;
                end
            end
            BLANK: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (w_scan_edge) begin
                    w_adv     = 1'b1;
                    w_cnt_nxt = BLANK_LOAD;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = DRIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            DRIVE: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (w_scan_edge) begin
                    w_adv       = 1'b1;
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = BLANK_LOAD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_wrap = w_adv && (r_idx == LAST_IDX);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_adv) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Shadow/active swap happens only at frame wrap so a frame never mixes old and new data.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_active     <= '0;
            r_active_dp  <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (load) begin
                r_shadow    <= data_in;
                r_shadow_dp <= dp_in;
            end
            if (w_wrap) begin
                if (load) begin
                    r_active    <= data_in;
                    r_active_dp <= dp_in;
                end else if (r_pending) begin
                    r_active    <= r_shadow;
                    r_active_dp <= r_shadow_dp;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_nibble = r_active[{r_idx, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] w_msnz;
    logic             w_lz_blank;

    always_comb begin
        w_msnz = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (r_active[4*k +: 4] != 4'h0) begin
                w_msnz = IDX_W'(k);
            end
        end
    end

    // Digit 0 can never exceed w_msnz, so it always shows.
    assign w_lz_blank = (r_idx > w_msnz) && !r_active_dp[r_idx];
    assign w_seg      = w_lz_blank ? SEG_BLANK : w_dec;
`else
    assign w_seg = w_dec;
`endif

    // Index and active data are stable whenever the next state is DRIVE, so the current values are used.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_anode   <= 8'hFF;
            r_cathode <= SEG_BLANK;
            r_dp      <= 1'b1;
        end else if (w_state_nxt == DRIVE) begin
            r_anode   <= ~(8'b0000_0001 << r_idx);
            r_cathode <= w_seg;
            r_dp      <= ~r_active_dp[r_idx];
        end else begin
            r_anode   <= 8'hFF;
            r_cathode <= SEG_BLANK;
            r_dp      <= 1'b1;
        end
    end

    assign anode          = r_anode;
    assign cathode        = r_cathode;
    assign dp             = r_dp;
    assign frame_done     = r_frame_done;
    assign update_pending = r_pending;

endmodule
